// File: rtl/mario_sprite_sequencer.sv
// Mario walk-sprite animation controller and ROM fetch pipeline.
// Picks the sprite frame and facing once per video frame. Then maps each scan
// pixel to a ROM address and returns a registered, transparency-masked color.
module mario_sprite_sequencer #(
  parameter int SPR_W    = 20,
  parameter int SPR_H    = 22,
  parameter int ANIM_DIV = 6
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_tick,
  input  logic        move_left,
  input  logic        move_right,
  input  logic        airborne,
  input  logic [9:0]  MarioX,
  input  logic [9:0]  MarioY,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic [8:0]  read_address,
  output logic [2:0]  frame_sel,
  output logic        mirror,
  input  logic [11:0] color_in,
  output logic        pixel_on,
  output logic [11:0] pixel_color
);

  // A one-bit counter is kept when ANIM_DIV is 1 so the vector stays legal.
  localparam int CNT_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ANIM_DIV - 1);
  localparam logic [9:0]  BOX_W = 10'(SPR_W);
  localparam logic [9:0]  BOX_H = 10'(SPR_H);
  localparam logic [8:0]  ROW_STRIDE = 9'(SPR_W);
  localparam logic [8:0]  COL_LAST = 9'(SPR_W - 1);
  localparam logic [11:0] TRANSPARENT = 12'h808;

  // The encoding doubles as the ROM bank select.
  typedef enum logic [2:0] {
    ST_STAND = 3'd0,
    ST_WALK1 = 3'd1,
    ST_WALK2 = 3'd2,
    ST_WALK3 = 3'd3,
    ST_JUMP  = 3'd4
  } anim_state_t;

  anim_state_t      state_q, state_d;
  logic [CNT_W-1:0] step_q, step_d;
  logic             mirror_q, mirror_d;
  logic             moving;

  logic [9:0] col, row;
  logic       in_box;
  logic       in_box_d1;
  logic [8:0] col_eff;
  logic [8:0] addr_calc;
  logic       opaque;

  assign moving    = move_left ^ move_right;
  assign frame_sel = state_q;
  assign mirror    = mirror_q;

  // Animation state, step counter and facing load once per video frame.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= ST_STAND;
      step_q   <= '0;
      mirror_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      mirror_q <= mirror_d;
    end
  end

  // Next animation state. Everything holds unless frame_tick is high.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    mirror_d = mirror_q;
    if (frame_tick) begin
      if (move_right && !move_left) begin
        mirror_d = 1'b0;
      end else if (move_left && !move_right) begin
        mirror_d = 1'b1;
      end
      if (airborne) begin
        state_d = ST_JUMP;
        step_d  = '0;
      end else if (moving && (state_q == ST_STAND || state_q == ST_JUMP)) begin
        state_d = ST_WALK1;
        step_d  = '0;
      end else if (moving) begin
        if (step_q == CNT_LAST) begin
          step_d = '0;
          unique case (state_q)
            ST_WALK1: state_d = ST_WALK2;
            ST_WALK2: state_d = ST_WALK3;
            default:  state_d = ST_WALK1;
          endcase
        end else begin
          step_d = step_q + 1'b1;
        end
      end else begin
        state_d = ST_STAND;
        step_d  = '0;
      end
    end
  end

  // Sprite-relative coordinates. Unsigned wraparound pushes pixels left of or
  // above the sprite to large values, so a single compare rejects them.
  always_comb begin
    col       = DrawX - MarioX;
    row       = DrawY - MarioY;
    in_box    = (col < BOX_W) && (row < BOX_H);
    col_eff   = mirror_q ? (COL_LAST - col[8:0]) : col[8:0];
    addr_calc = (row[8:0] * ROW_STRIDE) + col_eff;
  end

  // First pipeline stage: ROM address and the box flag that travels with it.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      read_address <= 9'd0;
      in_box_d1    <= 1'b0;
    end else begin
      read_address <= in_box ? addr_calc : 9'd0;
      in_box_d1    <= in_box;
    end
  end

  assign opaque = in_box_d1 && (color_in != TRANSPARENT);

  // Second pipeline stage: masked color toward the VGA color mapper.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pixel_on    <= 1'b0;
      pixel_color <= 12'd0;
    end else begin
      pixel_on    <= opaque;
      pixel_color <= opaque ? color_in : 12'd0;
    end
  end

endmodule

// File: tb/tb_mario_sprite_sequencer.sv
// Directed bench for mario_sprite_sequencer with default parameters.
module tb_mario_sprite_sequencer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        frame_tick = 1'b0;
  logic        move_left = 1'b0;
  logic        move_right = 1'b0;
  logic        airborne = 1'b0;
  logic [9:0]  MarioX = 10'd100;
  logic [9:0]  MarioY = 10'd50;
  logic [9:0]  DrawX = 10'd0;
  logic [9:0]  DrawY = 10'd0;
  logic [11:0] color_in = 12'h808;
  logic [8:0]  read_address;
  logic [2:0]  frame_sel;
  logic        mirror;
  logic        pixel_on;
  logic [11:0] pixel_color;

  int total = 0;
  int bad = 0;

  mario_sprite_sequencer dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_tick   (frame_tick),
    .move_left    (move_left),
    .move_right   (move_right),
    .airborne     (airborne),
    .MarioX       (MarioX),
    .MarioY       (MarioY),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .read_address (read_address),
    .frame_sel    (frame_sel),
    .mirror       (mirror),
    .color_in     (color_in),
    .pixel_on     (pixel_on),
    .pixel_color  (pixel_color)
  );

  // Free-running pixel clock.
  always #5 Clk = ~Clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick_clock();
    @(posedge Clk);
    #1;
  endtask

  // One-cycle frame_tick pulse.
  task automatic apply_stimulus();
    frame_tick = 1'b1;
    tick_clock();
    frame_tick = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_frame_sel"}, 32'(frame_sel), 32'd0);
    check_output({tag, "_mirror"}, 32'(mirror), 32'd0);
    check_output({tag, "_read_address"}, 32'(read_address), 32'd0);
    check_output({tag, "_pixel_on"}, 32'(pixel_on), 32'd0);
    check_output({tag, "_pixel_color"}, 32'(pixel_color), 32'd0);
  endtask

  initial begin
    // Reset applied asynchronously, before any clock edge.
    #1 Reset = 1'b1;
    #2;
    check_reset_outputs("reset_async");
    tick_clock();
    tick_clock();
    Reset = 1'b0;
    tick_clock();
    tick_clock();
    check_reset_outputs("after_release");

    // Walk right for 20 frames: step every 6 ticks.
    move_right = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      apply_stimulus();
      if (i == 1 || i == 6 || i == 7 || i == 12 || i == 13 || i == 18 || i == 19 || i == 20) begin
        logic [2:0] exp_sel;
        if (i < 7) exp_sel = 3'd1;
        else if (i < 13) exp_sel = 3'd2;
        else if (i < 19) exp_sel = 3'd3;
        else exp_sel = 3'd1;
        check_output($sformatf("walk_tick%0d_frame_sel", i), 32'(frame_sel), 32'(exp_sel));
      end
    end
    check_output("walk_mirror", 32'(mirror), 32'd0);

    // Address generation: col 3, row 2, not mirrored.
    DrawX = 10'd103;
    DrawY = 10'd52;
    tick_clock();
    check_output("addr_no_mirror", 32'(read_address), 32'd43);
    color_in = 12'hF30;
    tick_clock();
    check_output("opaque_pixel_on", 32'(pixel_on), 32'd1);
    check_output("opaque_pixel_color", 32'(pixel_color), 32'hF30);
    color_in = 12'h808;
    tick_clock();
    check_output("transparent_pixel_on", 32'(pixel_on), 32'd0);
    check_output("transparent_pixel_color", 32'(pixel_color), 32'd0);

    // Turn left: the tick cycle still uses the old facing.
    move_right = 1'b0;
    move_left = 1'b1;
    apply_stimulus();
    check_output("tick_cycle_old_mirror_addr", 32'(read_address), 32'd43);
    check_output("left_mirror", 32'(mirror), 32'd1);
    check_output("left_frame_sel", 32'(frame_sel), 32'd1);
    tick_clock();
    check_output("addr_mirror", 32'(read_address), 32'd56);

    // Box edges.
    DrawX = 10'd99;
    color_in = 12'hF30;
    tick_clock();
    check_output("left_of_box_addr", 32'(read_address), 32'd0);
    tick_clock();
    check_output("left_of_box_pixel_on", 32'(pixel_on), 32'd0);
    check_output("left_of_box_pixel_color", 32'(pixel_color), 32'd0);
    DrawX = 10'd103;
    tick_clock();
    check_output("back_in_box_addr", 32'(read_address), 32'd56);
    DrawX = 10'd120;
    tick_clock();
    check_output("right_of_box_addr", 32'(read_address), 32'd0);

    // Finish WALK1 (counter at 2) and reach WALK2.
    for (int i = 1; i <= 4; i++) begin
      apply_stimulus();
      if (i == 3) check_output("walk1_hold_frame_sel", 32'(frame_sel), 32'd1);
    end
    check_output("walk2_frame_sel", 32'(frame_sel), 32'd2);

    // Jump with no direction held: facing is kept.
    move_left = 1'b0;
    airborne = 1'b1;
    apply_stimulus();
    check_output("jump_frame_sel", 32'(frame_sel), 32'd4);
    check_output("jump_mirror", 32'(mirror), 32'd1);
    airborne = 1'b0;
    move_right = 1'b1;
    apply_stimulus();
    check_output("land_frame_sel", 32'(frame_sel), 32'd1);
    check_output("land_mirror", 32'(mirror), 32'd0);
    move_right = 1'b0;
    apply_stimulus();
    check_output("idle_frame_sel", 32'(frame_sel), 32'd0);
    check_output("idle_mirror", 32'(mirror), 32'd0);

    // Walk left to WALK3, then hold both directions.
    DrawX = 10'd103;
    color_in = 12'hF30;
    move_left = 1'b1;
    for (int i = 1; i <= 13; i++) apply_stimulus();
    check_output("walk3_frame_sel", 32'(frame_sel), 32'd3);
    check_output("walk3_mirror", 32'(mirror), 32'd1);
    move_right = 1'b1;
    apply_stimulus();
    check_output("both_frame_sel", 32'(frame_sel), 32'd0);
    check_output("both_mirror", 32'(mirror), 32'd1);
    check_output("pre_reset_pixel_on", 32'(pixel_on), 32'd1);
    check_output("pre_reset_addr", 32'(read_address), 32'd56);

    // Reset mid-cycle, two cycles after the STAND tick.
    tick_clock();
    #2 Reset = 1'b1;
    #1;
    check_reset_outputs("reset_mid");
    tick_clock();
    Reset = 1'b0;
    move_left = 1'b0;
    apply_stimulus();
    check_output("post_reset_frame_sel", 32'(frame_sel), 32'd1);
    check_output("post_reset_mirror", 32'(mirror), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
